// File: rtl/cache_burst_bridge.sv
// rtl/cache_burst_bridge.sv - cache-to-memory bridge: 4x16-bit burst reads, single-word writes
// Optional write posting: define CACHE_BRIDGE_WRITE_POST_EN for a 1-entry posted write buffer.
module cache_burst_bridge (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cache_addr,
  input  logic        cache_req,
  input  logic        cache_rw,
  input  logic [15:0] cache_wdata,
  output logic [15:0] cache_rdata,
  output logic        cache_fill,
  output logic        cache_wack,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_CMD     = 3'd1,
    RD_COLLECT = 3'd2,
    RD_REPLAY  = 3'd3,
    WR_CMD     = 3'd4,
    WR_DONE    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [15:0] rbuf [4];
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        wack_q;
  logic        rd_issue;

`ifdef CACHE_BRIDGE_WRITE_POST_EN
  logic        pb_valid;
  logic [31:0] pb_addr;
  logic [15:0] pb_data;
  logic        pb_take;

  // A write is accepted into the post buffer straight from IDLE when it is empty
  assign pb_take  = (state == IDLE) && cache_req && !cache_rw && !pb_valid;
  // Reads hold off while a posted write still owns the command bus
  assign rd_issue = (state == RD_CMD) && !pb_valid;
`else
  assign rd_issue = (state == RD_CMD);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cache_req) begin
          if (cache_rw) begin
            state_nxt = RD_CMD;
          end else begin
`ifdef CACHE_BRIDGE_WRITE_POST_EN
            if (!pb_valid) state_nxt = WR_DONE;
`else
            state_nxt = WR_CMD;
`endif
          end
        end
      end
      RD_CMD:     if (rd_issue && mem_ack) state_nxt = RD_COLLECT;
      RD_COLLECT: if (mem_rvalid && (cnt == 2'd3)) state_nxt = RD_REPLAY;
      RD_REPLAY:  if (cnt == 2'd3) state_nxt = IDLE;
      WR_CMD:     if (mem_ack) state_nxt = WR_DONE;
      WR_DONE:    if (!cache_req) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Datapath: command capture, burst buffer, word/replay counter, write acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 16'd0;
      wack_q  <= 1'b0;
      for (int i = 0; i < 4; i++) rbuf[i] <= 16'd0;
`ifdef CACHE_BRIDGE_WRITE_POST_EN
      pb_valid <= 1'b0;
      pb_addr  <= 32'd0;
      pb_data  <= 16'd0;
`endif
    end else begin
      wack_q <= 1'b0;
      if ((state == IDLE) && cache_req) begin
        addr_q  <= cache_rw ? {cache_addr[31:3], 3'b000} : cache_addr;
        wdata_q <= cache_wdata;
      end
      // One counter serves both collect (slot index) and replay (word index);
      // it wraps to 0 on the 4th word, which is exactly the replay start
      if (state == IDLE) begin
        cnt <= 2'd0;
      end else if ((state == RD_COLLECT) && mem_rvalid) begin
        rbuf[cnt] <= mem_rdata;
        cnt       <= cnt + 2'd1;
      end else if (state == RD_REPLAY) begin
        cnt <= cnt + 2'd1;
      end
`ifdef CACHE_BRIDGE_WRITE_POST_EN
      if (pb_take) begin
        pb_valid <= 1'b1;
        pb_addr  <= cache_addr;
        pb_data  <= cache_wdata;
        wack_q   <= 1'b1;
      end else if (pb_valid && mem_ack) begin
        pb_valid <= 1'b0;
      end
`else
      if ((state == WR_CMD) && mem_ack) wack_q <= 1'b1;
`endif
    end
  end

  // Outputs decoded from state; rdata falls back to slot 3 so it holds the last replayed word
  always_comb begin
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    cache_fill  = 1'b0;
    cache_rdata = rbuf[3];
    case (state)
      RD_CMD: mem_req = rd_issue;
      RD_REPLAY: begin
        cache_rdata = rbuf[cnt];
        cache_fill  = (cnt == 2'd0);
      end
      WR_CMD: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
      end
      default: ;
    endcase
`ifdef CACHE_BRIDGE_WRITE_POST_EN
    if (pb_valid) begin
      mem_req = 1'b1;
      mem_wr  = 1'b1;
    end
    mem_addr  = pb_valid ? pb_addr : addr_q;
    mem_wdata = pb_valid ? pb_data : wdata_q;
`else
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
`endif
  end

  assign cache_wack = wack_q;

endmodule

// File: tb/tb_cache_burst_bridge.sv
// tb/tb_cache_burst_bridge.sv - directed self-checking bench for cache_burst_bridge
module tb_cache_burst_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cache_addr;
  logic        cache_req;
  logic        cache_rw;
  logic [15:0] cache_wdata;
  logic [15:0] cache_rdata;
  logic        cache_fill;
  logic        cache_wack;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cache_burst_bridge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cache_addr  (cache_addr),
    .cache_req   (cache_req),
    .cache_rw    (cache_rw),
    .cache_wdata (cache_wdata),
    .cache_rdata (cache_rdata),
    .cache_fill  (cache_fill),
    .cache_wack  (cache_wack),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required finish before 100us");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Collect phase starting the cycle after mem_ack, then the 4-cycle replay and hold
  task automatic collect_replay(input logic [63:0] w, input int g1, input int g2, input int g3,
                                input bit stray, input string tg);
    int g;
    cyc; mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = w[15:0];
    mid; chk({tg, "_req_dropped"}, 32'(mem_req), 32'd0);
    for (int i = 1; i < 4; i++) begin
      g = (i == 1) ? g1 : ((i == 2) ? g2 : g3);
      for (int k = 0; k < g; k++) begin
        cyc; mem_rvalid = 1'b0;
        mid; chk({tg, "_gap_fill"}, 32'(cache_fill), 32'd0);
      end
      cyc; mem_rvalid = 1'b1; mem_rdata = w[16*i +: 16];
      mid; chk({tg, "_collect_fill"}, 32'(cache_fill), 32'd0);
    end
    cyc; mem_rvalid = stray; mem_rdata = 16'hDEAD;
    mid; chk({tg, "_fill0"}, 32'(cache_fill), 32'd1);
         chk({tg, "_word0"}, 32'(cache_rdata), 32'(w[15:0]));
    for (int i = 1; i < 4; i++) begin
      cyc; mem_rvalid = 1'b0;
      mid; chk({tg, "_fillN"}, 32'(cache_fill), 32'd0);
           chk({tg, "_wordN"}, 32'(cache_rdata), 32'(w[16*i +: 16]));
    end
    cyc;
    mid; chk({tg, "_hold"}, 32'(cache_rdata), 32'(w[63:48]));
         chk({tg, "_hold_fill"}, 32'(cache_fill), 32'd0);
         chk({tg, "_idle_req"}, 32'(mem_req), 32'd0);
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [31:0] exp_a, input logic [63:0] w,
                          input int g1, input int g2, input int g3, input bit stray,
                          input string tg);
    cyc; cache_req = 1'b1; cache_rw = 1'b1; cache_addr = a;
    mid; chk({tg, "_idle_noreq"}, 32'(mem_req), 32'd0);
    cyc; cache_req = 1'b0;
    mid; chk({tg, "_cmd_req"}, 32'(mem_req), 32'd1);
         chk({tg, "_cmd_wr"}, 32'(mem_wr), 32'd0);
         chk({tg, "_cmd_addr"}, mem_addr, exp_a);
    cyc; mem_ack = 1'b1;
    mid; chk({tg, "_cmd_held"}, 32'(mem_req), 32'd1);
    collect_replay(w, g1, g2, g3, stray, tg);
  endtask

  initial begin
    reset_n     = 1'b0;
    cache_addr  = 32'd0;
    cache_req   = 1'b0;
    cache_rw    = 1'b0;
    cache_wdata = 16'd0;
    mem_ack     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 16'd0;

    repeat (2) cyc;
    chk("rst_fill",  32'(cache_fill), 32'd0);
    chk("rst_wack",  32'(cache_wack), 32'd0);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_wr",    32'(mem_wr), 32'd0);
    chk("rst_rdata", 32'(cache_rdata), 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    cyc; reset_n = 1'b1;

    // Back-to-back burst read
    rd_burst(32'h0000_1236, 32'h0000_1230, 64'h00A3_00A2_00A1_00A0, 0, 0, 0, 1'b0, "rd1");

    // Stray ack and rvalid while idle must change nothing
    cyc; mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
    mid; chk("idle_ack_req", 32'(mem_req), 32'd0);
    cyc; mem_ack = 1'b0; mem_rvalid = 1'b0;
    mid; chk("idle_rv_rdata", 32'(cache_rdata), 32'h0000_00A3);
         chk("idle_ack_wack", 32'(cache_wack), 32'd0);
         chk("idle_ack_req2", 32'(mem_req), 32'd0);

    // Gapped burst with a 5th stray word during replay
    rd_burst(32'h0000_1236, 32'h0000_1230, 64'h00A3_00A2_00A1_00A0, 0, 3, 1, 1'b1, "rd2");

`ifndef CACHE_BRIDGE_WRITE_POST_EN
    // Held write, ack on the 4th command cycle
    cyc; cache_req = 1'b1; cache_rw = 1'b0; cache_addr = 32'h0000_0100; cache_wdata = 16'hBEEF;
    mid; chk("wr_idle_req", 32'(mem_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc;
      mid; chk("wr_cmd_req", 32'(mem_req), 32'd1);
           chk("wr_cmd_wr", 32'(mem_wr), 32'd1);
    end
    chk("wr_addr",  mem_addr, 32'h0000_0100);
    chk("wr_wdata", 32'(mem_wdata), 32'h0000_BEEF);
    cyc; mem_ack = 1'b1;
    mid; chk("wr_ack_req", 32'(mem_req), 32'd1);
         chk("wr_ack_early", 32'(cache_wack), 32'd0);
    cyc; mem_ack = 1'b0;
    mid; chk("wr_wack", 32'(cache_wack), 32'd1);
         chk("wr_req_drop", 32'(mem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc;
      mid; chk("wr_held_wack", 32'(cache_wack), 32'd0);
           chk("wr_held_noreissue", 32'(mem_req), 32'd0);
    end
    cyc; cache_req = 1'b0;
    mid; chk("wr_release_req", 32'(mem_req), 32'd0);

    // Write acknowledged in the same cycle mem_req first rises
    cyc; cache_req = 1'b1; cache_addr = 32'h0000_0204; cache_wdata = 16'h1234;
    mid; chk("wr2_idle_req", 32'(mem_req), 32'd0);
    cyc; mem_ack = 1'b1;
    mid; chk("wr2_req", 32'(mem_req), 32'd1);
         chk("wr2_addr", mem_addr, 32'h0000_0204);
         chk("wr2_wdata", 32'(mem_wdata), 32'h0000_1234);
    cyc; mem_ack = 1'b0; cache_req = 1'b0;
    mid; chk("wr2_wack", 32'(cache_wack), 32'd1);
    cyc;
    mid; chk("wr2_wack_once", 32'(cache_wack), 32'd0);
         chk("wr2_idle", 32'(mem_req), 32'd0);
`else
    // Posted write followed at once by a read; write ack arrives 6 cycles after accept
    cyc; cache_req = 1'b1; cache_rw = 1'b0; cache_addr = 32'h0000_0300; cache_wdata = 16'hCAFE;
    mid; chk("pw_idle_req", 32'(mem_req), 32'd0);
    cyc; cache_req = 1'b0;
    mid; chk("pw_wack", 32'(cache_wack), 32'd1);
         chk("pw_req", 32'(mem_req), 32'd1);
         chk("pw_wr", 32'(mem_wr), 32'd1);
         chk("pw_addr", mem_addr, 32'h0000_0300);
         chk("pw_wdata", 32'(mem_wdata), 32'h0000_CAFE);
    cyc; cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 32'h0000_1236;
    mid; chk("pw_wack_once", 32'(cache_wack), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc; cache_req = 1'b0;
      mid; chk("pw_rd_blocked_wr", 32'(mem_wr), 32'd1);
           chk("pw_rd_blocked_addr", mem_addr, 32'h0000_0300);
    end
    cyc; mem_ack = 1'b1;
    mid; chk("pw_ack_wr", 32'(mem_wr), 32'd1);
    cyc; mem_ack = 1'b1;
    mid; chk("pw_rd_req", 32'(mem_req), 32'd1);
         chk("pw_rd_wr", 32'(mem_wr), 32'd0);
         chk("pw_rd_addr", mem_addr, 32'h0000_1230);
    collect_replay(64'h00A3_00A2_00A1_00A0, 0, 0, 0, 1'b0, "pw_rd");
`endif

    // Reset after the 2nd word of a burst
    cyc; cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 32'h0000_2008;
    cyc; cache_req = 1'b0;
    cyc; mem_ack = 1'b1;
    cyc; mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h0101;
    cyc; mem_rdata = 16'h0202;
    cyc; mem_rvalid = 1'b0; reset_n = 1'b0;
    #1;
    chk("mrst_fill",  32'(cache_fill), 32'd0);
    chk("mrst_wack",  32'(cache_wack), 32'd0);
    chk("mrst_req",   32'(mem_req), 32'd0);
    chk("mrst_wr",    32'(mem_wr), 32'd0);
    chk("mrst_rdata", 32'(cache_rdata), 32'd0);
    chk("mrst_addr",  mem_addr, 32'd0);
    chk("mrst_wdata", 32'(mem_wdata), 32'd0);
    cyc; reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc; mem_rvalid = (k == 1);
      mid; chk("post_rst_fill", 32'(cache_fill), 32'd0);
           chk("post_rst_req", 32'(mem_req), 32'd0);
    end
    cyc; mem_rvalid = 1'b0;

    // Normal read after the aborted one
    rd_burst(32'h0000_0ABC, 32'h0000_0AB8, 64'h4444_3333_2222_1111, 1, 0, 2, 1'b0, "rd3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_burst_bridge.md
CACHE_BURST_BRIDGE -- requirements
Module: cache_burst_bridge

Interface
REQ-001 SHALL have ports, one per line (name  direction  width  meaning), clock and reset first:
  clk  in  1  single clock; all logic on rising edge
  reset_n  in  1  asynchronous, active-low reset
  cache_addr  in  32  cache-side byte address
  cache_req  in  1  cache request, level
  cache_rw  in  1  1 = burst read, 0 = single-word write
  cache_wdata  in  16  write data
  cache_rdata  out  16  replayed burst word
  cache_fill  out  1  one-cycle marker: word 0 is on cache_rdata
  cache_wack  out  1  one-cycle write acknowledge
  mem_addr  out  32  controller address
  mem_req  out  1  controller command request
  mem_wr  out  1  1 = write command
  mem_wdata  out  16  controller write data
  mem_ack  in  1  command accepted, one cycle
  mem_rvalid  in  1  one read word valid on mem_rdata
  mem_rdata  in  16  controller read data
REQ-002 SHALL have no parameters; burst length fixed at 4 x 16-bit words.

Function
REQ-003 SHALL implement states IDLE, RD_CMD, RD_COLLECT, RD_REPLAY, WR_CMD, WR_DONE.
REQ-004 IDLE SHALL sample cache_req=1 and select the next state: cache_rw=1 -> RD_CMD, cache_rw=0 -> WR_CMD; cache_req=0 -> stay in IDLE.
REQ-005 RD_CMD SHALL drive mem_req=1, mem_wr=0, mem_addr={cache_addr[31:3],3'b000}; on mem_ack it SHALL drop mem_req next cycle and enter RD_COLLECT.
REQ-006 RD_COLLECT SHALL store each mem_rvalid word into buffer slot 0..3 in arrival order; gaps between words are permitted.
REQ-006a When the 4th word arrives, RD_COLLECT SHALL enter RD_REPLAY.
REQ-007 mem_rvalid pulses outside RD_COLLECT, and any beyond the 4th, SHALL be ignored.
REQ-008 RD_REPLAY SHALL drive slot 0..3 on cache_rdata on four consecutive cycles, with cache_fill=1 only on the slot-0 cycle, then return to IDLE.
REQ-008a Latency from the 4th mem_rvalid to cache_fill SHALL be exactly 1 cycle.
REQ-009 cache_rdata SHALL hold its last value outside replay.
REQ-009a cache_fill SHALL never be asserted twice for one request.
REQ-010 A drop of cache_req during RD_CMD or RD_COLLECT SHALL NOT abort the burst; replay still occurs.
REQ-011 WR_CMD SHALL drive mem_req=1, mem_wr=1, mem_addr=cache_addr, mem_wdata=cache_wdata (latched at IDLE exit) until mem_ack.
REQ-011a On mem_ack, WR_CMD SHALL pulse cache_wack for 1 cycle and enter WR_DONE.
REQ-012 WR_DONE SHALL stay until cache_req=0, then go to IDLE; this prevents double-issue of a held write request.
REQ-013 mem_req SHALL never be asserted in IDLE, RD_COLLECT, RD_REPLAY or WR_DONE.
REQ-014 A mem_ack arriving in the same cycle mem_req first rises SHALL be honoured.
REQ-014a A mem_ack arriving while mem_req=0 SHALL be ignored.

Reset
REQ-015 reset_n=0 SHALL, asynchronously: set state IDLE; set cache_fill, cache_wack, mem_req, mem_wr to 0; set cache_rdata, mem_addr, mem_wdata to 0; clear the buffer count.
REQ-016 Reset mid-burst or mid-write SHALL discard the operation with no cache_fill/cache_wack after release.
REQ-016a After reset release, the first cycle SHALL be IDLE.

Configuration
REQ-017 Macro CACHE_BRIDGE_WRITE_POST_EN SHALL select write posting.
REQ-017a Defined: an IDLE write SHALL be captured into a 1-entry post buffer and cache_wack pulsed the next cycle, while the memory write proceeds independently.
REQ-017b Defined: a subsequent read SHALL NOT issue mem_req until the posted write has received mem_ack (read-after-write ordering).
REQ-017c Defined: a second write while the buffer is full SHALL wait in IDLE.
REQ-018 Undefined: cache_wack SHALL follow mem_ack as in REQ-011a, and no post buffer SHALL exist.

Verification
REQ-019 Read 0x00001236, mem_ack at cycle 2, rvalid 0xA0,0xA1,0xA2,0xA3 back-to-back -> mem_addr=0x00001230; cache_fill 1 cycle after the 4th word with 0xA0; then 0xA1,0xA2,0xA3 on consecutive cycles.
REQ-020 Same read with rvalid gaps of 0/3/1 cycles and a 5th stray rvalid -> identical replay; stray word ignored.
REQ-021 Write 0x00000100 data 0xBEEF held 10 cycles, mem_ack after 4 cycles -> single mem_req with mem_wr=1, mem_wdata=0xBEEF; one cache_wack; no reissue while cache_req is held.
REQ-022 reset_n low after 2nd rvalid, then release -> all outputs 0; no cache_fill; the next read works normally.
REQ-023 With CACHE_BRIDGE_WRITE_POST_EN: write then immediate read, mem_ack for the write delayed 6 cycles -> cache_wack 1 cycle after accept; read mem_req not before the write mem_ack.
